decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 162 ++++++++++++++++
 tb/tb_decode_stage.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Instruction decode stage: decodes a 16-bit instruction on acceptance and
// queues the decoded bundle in a small FIFO toward the execute stage.
module decode_stage #(
    parameter int DATA_WIDTH     = 16,
    parameter int BUF_DEPTH      = 2,
    parameter int REG_ADDR_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [15:0]               in_instr,
    input  logic [DATA_WIDTH-1:0]     in_pc,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [3:0]                out_op,
    output logic [REG_ADDR_WIDTH-1:0] out_dr,
    output logic [REG_ADDR_WIDTH-1:0] out_sr1,
    output logic [REG_ADDR_WIDTH-1:0] out_sr2,
    output logic [DATA_WIDTH-1:0]     out_imm,
    output logic                      out_reg_write,
    output logic                      out_mem_read,
    output logic                      out_mem_write,
    output logic                      out_is_branch,
    output logic                      out_use_imm,
    output logic [3:0]                out_br_mask,
    output logic                      out_sh_left,
    output logic                      out_sh_arith,
    output logic                      out_illegal,
    output logic [DATA_WIDTH-1:0]     out_pc
);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_NOT  = 4'h6;
    localparam logic [3:0] OP_SH   = 4'h7;
    localparam logic [3:0] OP_LD   = 4'h8;
    localparam logic [3:0] OP_ST   = 4'h9;
    localparam logic [3:0] OP_LDI  = 4'hA;
    localparam logic [3:0] OP_B    = 4'hB;
    localparam logic [3:0] OP_ADDI = 4'hC;
    localparam logic [3:0] OP_AIPC = 4'hD;

    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int BW = 4 + 3*REG_ADDR_WIDTH + DATA_WIDTH + 5 + 4 + 2 + 1 + DATA_WIDTH;

    logic [3:0]            op;
    logic [DATA_WIDTH-1:0] dec_imm;
    logic                  dec_rw, dec_mr, dec_mw, dec_br, dec_ui, dec_ill;
    logic [BW-1:0]         dec_bundle;

    assign op = in_instr[15:12];

    always_comb begin
        dec_imm = '0;
        dec_rw  = 1'b0;
        dec_mr  = 1'b0;
        dec_mw  = 1'b0;
        dec_br  = 1'b0;
        dec_ui  = 1'b0;
        dec_ill = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR, OP_NOT: dec_rw = 1'b1;
            OP_SH: begin
                dec_rw  = 1'b1;
                dec_ui  = 1'b1;
                dec_imm = {{(DATA_WIDTH-5){1'b0}}, in_instr[4:0]};
            end
            OP_LD: begin
                dec_rw = 1'b1;
                dec_mr = 1'b1;
            end
            OP_ST: dec_mw = 1'b1;
            OP_LDI: begin
                dec_rw  = 1'b1;
                dec_ui  = 1'b1;
                dec_imm = {{(DATA_WIDTH-8){1'b0}}, in_instr[7:0]};
            end
            OP_B: begin
                dec_br  = 1'b1;
                dec_imm = {{(DATA_WIDTH-8){in_instr[7]}}, in_instr[7:0]};
            end
            OP_ADDI: begin
                dec_rw  = 1'b1;
                dec_ui  = 1'b1;
                dec_imm = {{(DATA_WIDTH-4){in_instr[3]}}, in_instr[3:0]};
            end
            OP_AIPC: begin
                dec_rw  = 1'b1;
                dec_ui  = 1'b1;
                dec_imm = {{(DATA_WIDTH-8){in_instr[7]}}, in_instr[7:0]};
            end
            default: dec_ill = 1'b1;
        endcase
    end

    // Branch mask and shift bits pass through raw even for non-branch/non-shift ops.
    assign dec_bundle = {op, in_instr[11:8], in_instr[7:4], in_instr[3:0], dec_imm,
                         dec_rw, dec_mr, dec_mw, dec_br, dec_ui,
                         in_instr[11:8], in_instr[7], in_instr[6], dec_ill, in_pc};

    logic [BW-1:0] mem_q [BUF_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          in_ready_q, in_ready_d;
    logic          push, pop;

    assign out_valid = (count_q != '0);
    assign in_ready  = in_ready_q;
    assign push      = in_valid & in_ready_q & ~flush;
    assign pop       = out_valid & out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
        in_ready_d = (count_d < CW'(BUF_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Storage is data-only; validity is tracked entirely by count_q.
    always_ff @(posedge clk) begin
        if (push && !rst) mem_q[wr_ptr_q] <= dec_bundle;
    end

    assign {out_op, out_dr, out_sr1, out_sr2, out_imm,
            out_reg_write, out_mem_read, out_mem_write, out_is_branch, out_use_imm,
            out_br_mask, out_sh_left, out_sh_arith, out_illegal, out_pc} = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode fields, backpressure, flush and reset,
// with a 32-bit-datapath instance sharing the same stimulus.
module tb_decode_stage;
    logic        clk = 1'b0;
    logic        rst, in_valid, flush, out_ready;
    logic [15:0] in_instr;
    logic [15:0] in_pc;
    logic        in_ready, out_valid;
    logic [3:0]  out_op, out_dr, out_sr1, out_sr2, out_br_mask;
    logic [15:0] out_imm, out_pc;
    logic        out_reg_write, out_mem_read, out_mem_write, out_is_branch, out_use_imm;
    logic        out_sh_left, out_sh_arith, out_illegal;

    logic        w_in_ready, w_out_valid;
    logic [3:0]  w_op, w_dr, w_sr1, w_sr2, w_br_mask;
    logic [31:0] w_imm, w_pc;
    logic        w_rw, w_mr, w_mw, w_br, w_ui, w_shl, w_sha, w_ill;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
        .out_dr(out_dr), .out_sr1(out_sr1), .out_sr2(out_sr2), .out_imm(out_imm),
        .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .out_is_branch(out_is_branch),
        .out_use_imm(out_use_imm), .out_br_mask(out_br_mask),
        .out_sh_left(out_sh_left), .out_sh_arith(out_sh_arith),
        .out_illegal(out_illegal), .out_pc(out_pc)
    );

    decode_stage #(.DATA_WIDTH(32)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_instr(in_instr), .in_pc({16'h0000, in_pc}), .flush(flush),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_op(w_op),
        .out_dr(w_dr), .out_sr1(w_sr1), .out_sr2(w_sr2), .out_imm(w_imm),
        .out_reg_write(w_rw), .out_mem_read(w_mr), .out_mem_write(w_mw),
        .out_is_branch(w_br), .out_use_imm(w_ui), .out_br_mask(w_br_mask),
        .out_sh_left(w_shl), .out_sh_arith(w_sha), .out_illegal(w_ill), .out_pc(w_pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic offer(input logic [15:0] instr, input logic [15:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_instr = '0; in_pc = '0;
        step(); step();
        rst = 1'b0;
        step();
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);

        // ADDI on both widths
        offer(16'hC12F, 16'h0040);
        step();
        in_valid = 1'b0;
        chk("addi valid", {31'd0, out_valid}, 32'd1);
        chk("addi op", {28'd0, out_op}, 32'hC);
        chk("addi dr", {28'd0, out_dr}, 32'd1);
        chk("addi sr1", {28'd0, out_sr1}, 32'd2);
        chk("addi imm", {16'd0, out_imm}, 32'h0000FFFF);
        chk("addi use_imm", {31'd0, out_use_imm}, 32'd1);
        chk("addi reg_write", {31'd0, out_reg_write}, 32'd1);
        chk("addi pc", {16'd0, out_pc}, 32'h0040);
        chk("addi32 imm", w_imm, 32'hFFFFFFFF);
        chk("addi32 pc", w_pc, 32'h00000040);
        step();
        chk("addi popped", {31'd0, out_valid}, 32'd0);

        // LDI then B back to back
        offer(16'hA3F0, 16'h0042);
        step();
        offer(16'hB480, 16'h0044);
        chk("ldi op", {28'd0, out_op}, 32'hA);
        chk("ldi imm", {16'd0, out_imm}, 32'h00F0);
        chk("ldi dr", {28'd0, out_dr}, 32'd3);
        step();
        in_valid = 1'b0;
        chk("b valid", {31'd0, out_valid}, 32'd1);
        chk("b is_branch", {31'd0, out_is_branch}, 32'd1);
        chk("b br_mask", {28'd0, out_br_mask}, 32'h4);
        chk("b imm", {16'd0, out_imm}, 32'hFF80);
        chk("b reg_write", {31'd0, out_reg_write}, 32'd0);
        chk("b pc", {16'd0, out_pc}, 32'h0044);

        // Illegal, SH, LD, ST, AIPC streamed
        offer(16'hE123, 16'h0050);
        step();
        offer(16'h7FDF, 16'h0052);
        chk("ill illegal", {31'd0, out_illegal}, 32'd1);
        chk("ill flags", {27'd0, out_reg_write, out_mem_read, out_mem_write, out_is_branch, out_use_imm}, 32'd0);
        chk("ill imm", {16'd0, out_imm}, 32'd0);
        chk("ill br_mask raw", {28'd0, out_br_mask}, 32'h1);
        step();
        offer(16'h8123, 16'h0054);
        chk("sh imm", {16'd0, out_imm}, 32'h001F);
        chk("sh shbits", {30'd0, out_sh_left, out_sh_arith}, 32'd3);
        chk("sh use_imm", {31'd0, out_use_imm}, 32'd1);
        step();
        offer(16'h9123, 16'h0056);
        chk("ld flags", {29'd0, out_reg_write, out_mem_read, out_mem_write}, 32'b110);
        step();
        offer(16'hD1FE, 16'h0058);
        chk("st flags", {29'd0, out_reg_write, out_mem_read, out_mem_write}, 32'b001);
        step();
        in_valid = 1'b0;
        chk("aipc imm", {16'd0, out_imm}, 32'hFFFE);
        chk("aipc ui_rw", {30'd0, out_use_imm, out_reg_write}, 32'b11);
        step();
        chk("stream drained", {31'd0, out_valid}, 32'd0);

        // Backpressure: three offered, two accepted
        out_ready = 1'b0;
        offer(16'h0123, 16'h0100);
        step();
        chk("bp in_ready after 1", {31'd0, in_ready}, 32'd1);
        offer(16'h1456, 16'h0102);
        step();
        chk("bp in_ready full", {31'd0, in_ready}, 32'd0);
        offer(16'h2789, 16'h0104);
        step();
        chk("bp hold in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp hold op", {28'd0, out_op}, 32'h0);
        chk("bp hold pc", {16'd0, out_pc}, 32'h0100);
        out_ready = 1'b1;
        step();
        chk("bp 2nd op", {28'd0, out_op}, 32'h1);
        chk("bp 2nd pc", {16'd0, out_pc}, 32'h0102);
        chk("bp in_ready reopen", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        chk("bp 3rd op", {28'd0, out_op}, 32'h2);
        chk("bp 3rd pc", {16'd0, out_pc}, 32'h0104);
        step();
        chk("bp drained", {31'd0, out_valid}, 32'd0);

        // Flush with two buffered and one offered
        out_ready = 1'b0;
        offer(16'h3111, 16'h0200);
        step();
        offer(16'h4222, 16'h0202);
        step();
        chk("fl full", {31'd0, in_ready}, 32'd0);
        offer(16'h5333, 16'h0204);
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("fl out_valid", {31'd0, out_valid}, 32'd0);
        chk("fl in_ready", {31'd0, in_ready}, 32'd1);
        step();
        chk("fl dropped", {31'd0, out_valid}, 32'd0);
        // Flush while in_ready=1 still drops the offered instruction
        offer(16'h6444, 16'h0206);
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl empty drop", {31'd0, out_valid}, 32'd0);

        // Reset mid-stream with a full FIFO
        out_ready = 1'b0;
        offer(16'h0AAA, 16'h0300);
        step();
        offer(16'h0BBB, 16'h0302);
        step();
        chk("rs full", {31'd0, in_ready}, 32'd0);
        offer(16'h0CCC, 16'h0304);
        rst = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0;
        chk("rs out_valid", {31'd0, out_valid}, 32'd0);
        chk("rs in_ready", {31'd0, in_ready}, 32'd1);
        chk("rs32 out_valid", {31'd0, w_out_valid}, 32'd0);
        step();
        chk("rs stays empty", {31'd0, out_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
